// File: rtl/interrupt_request_controller.sv
// Interrupt request controller: latches rising edges on the request lines, grants one at
// a time by lowest index, and releases the next grant only after RET plus a holdoff.
module interrupt_request_controller #(
    parameter int         NUM_IRQ    = 4,
    parameter logic [4:0] RET_OPCODE = 5'b10000,
    parameter int         HOLDOFF    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_en,
    input  logic [23:0]        ins,
    output logic               interrupt,
    output logic [2:0]         irq_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, HOLD} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      hold_cnt, hold_cnt_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] winner_onehot;
    logic [2:0]         winner_idx;
    logic [NUM_IRQ-1:0] clr;
    logic               grant;
    logic               ret_seen;
    logic               hold_done;

    assign rise      = irq_in & ~irq_prev;
    assign eligible  = pending & ~irq_mask & {NUM_IRQ{int_en}};
    assign ret_seen  = (ins[23:19] == RET_OPCODE);
    assign hold_done = (state == HOLD) && (hold_cnt == '0);

    // Lowest index wins: the first set bit found while scanning upward.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && (winner_onehot == '0)) begin
                winner_onehot[i] = 1'b1;
                winner_idx       = 3'(i);
            end
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        clr           = '0;
        grant         = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    state_next = ASSERT;
                    grant      = 1'b1;
                    clr        = winner_onehot;
                end
            end
            ASSERT: begin
                state_next = SERVICE;
            end
            SERVICE: begin
                if (ret_seen) begin
                    state_next    = HOLD;
                    hold_cnt_next = CW'(HOLDOFF - 1);
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            interrupt  <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            pending    <= '0;
            irq_prev   <= '1;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_cnt_next;
            interrupt <= (state_next == ASSERT);
            irq_prev  <= irq_in;
            // OR-ing rise after the clear lets a same-cycle new edge survive the grant.
            pending   <= (pending & ~clr) | rise;
            if (grant) begin
                irq_id     <= winner_idx;
                in_service <= 1'b1;
            end else if (hold_done) begin
                in_service <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed bench for interrupt_request_controller (NUM_IRQ=4, HOLDOFF=2) with
// hand-computed expectations checked by immediate assertions.
module tb_interrupt_request_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic [3:0]  irq_mask;
    logic        int_en;
    logic [23:0] ins;
    logic        interrupt;
    logic [2:0]  irq_id;
    logic        in_service;
    logic [3:0]  pending;

    int checks;
    int failures;

    localparam logic [23:0] RET_INS = {5'b10000, 19'd0};

    interrupt_request_controller #(
        .NUM_IRQ    (4),
        .RET_OPCODE (5'b10000),
        .HOLDOFF    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .int_en     (int_en),
        .ins        (ins),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic i, input logic [2:0] id,
                           input logic s, input logic [3:0] p);
        chk({tag, "_interrupt"}, 32'(interrupt), 32'(i));
        chk({tag, "_irq_id"}, 32'(irq_id), 32'(id));
        chk({tag, "_in_service"}, 32'(in_service), 32'(s));
        chk({tag, "_pending"}, 32'(pending), 32'(p));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        irq_in   = 4'b0000;
        irq_mask = 4'b0000;
        int_en   = 1'b1;
        ins      = 24'd0;
        step();
        step();
        chk_all("reset", 1'b0, 3'd0, 1'b0, 4'b0000);
        reset = 1'b0;
        step();

        // 1: single rise on line 2
        irq_in = 4'b0100;
        step();
        chk_all("t1_latch", 1'b0, 3'd0, 1'b0, 4'b0100);
        step();
        chk_all("t1_grant", 1'b1, 3'd2, 1'b1, 4'b0000);
        step();
        chk_all("t1_service", 1'b0, 3'd2, 1'b1, 4'b0000);
        ins = RET_INS;
        step();
        ins = 24'd0;
        chk("t1_hold_insvc", 32'(in_service), 32'd1);
        step();
        step();
        chk_all("t1_idle", 1'b0, 3'd2, 1'b0, 4'b0000);

        // 2: lines 1 and 3 together, lowest first
        irq_in = 4'b1110;
        step();
        chk("t2_latch", 32'(pending), 32'b1010);
        step();
        chk_all("t2_grant1", 1'b1, 3'd1, 1'b1, 4'b1000);
        step();
        ins = RET_INS;
        step();
        ins = 24'd0;
        chk_all("t2_hold", 1'b0, 3'd1, 1'b1, 4'b1000);
        step();
        step();
        chk_all("t2_idle", 1'b0, 3'd1, 1'b0, 4'b1000);
        step();
        chk_all("t2_grant3", 1'b1, 3'd3, 1'b1, 4'b0000);
        step();
        ins = RET_INS;
        step();
        ins = 24'd0;
        step();
        step();
        chk("t2_done", 32'(in_service), 32'd0);

        // 3: masked line latches but is not granted until unmasked
        irq_in = 4'b0000;
        step();
        irq_mask = 4'b0001;
        irq_in   = 4'b0001;
        step();
        chk("t3_latch", 32'(pending), 32'b0001);
        step();
        step();
        chk_all("t3_masked", 1'b0, 3'd3, 1'b0, 4'b0001);
        irq_mask = 4'b0000;
        step();
        chk_all("t3_grant0", 1'b1, 3'd0, 1'b1, 4'b0000);
        step();

        // 4: re-rise during service, second pulse HOLDOFF+2 cycles after RET
        irq_in = 4'b0000;
        step();
        irq_in = 4'b0001;
        step();
        chk_all("t4_relatch", 1'b0, 3'd0, 1'b1, 4'b0001);
        ins = RET_INS;
        step();
        ins = 24'd0;
        chk("t4_ret1", 32'(interrupt), 32'd0);
        step();
        step();
        chk("t4_ret3", 32'(interrupt), 32'd0);
        step();
        chk_all("t4_pulse", 1'b1, 3'd0, 1'b1, 4'b0000);
        step();

        // 5: reset during service with lines held high
        reset  = 1'b1;
        irq_in = 4'b1001;
        step();
        chk_all("t5_reset", 1'b0, 3'd0, 1'b0, 4'b0000);
        reset = 1'b0;
        step();
        step();
        step();
        chk_all("t5_held", 1'b0, 3'd0, 1'b0, 4'b0000);

        // 6a: RET in IDLE ignored
        ins = RET_INS;
        step();
        ins = 24'd0;
        step();
        chk_all("t6_ret_idle", 1'b0, 3'd0, 1'b0, 4'b0000);

        // 6b: RET during the ASSERT cycle ignored
        irq_in = 4'b1011;
        step();
        chk("t6_latch", 32'(pending), 32'b0010);
        step();
        chk_all("t6_assert", 1'b1, 3'd1, 1'b1, 4'b0000);
        ins = RET_INS;
        step();
        ins = 24'd0;
        chk("t6_after_assert", 32'(interrupt), 32'd0);
        step();
        step();
        step();
        chk("t6_still_insvc", 32'(in_service), 32'd1);
        ins = RET_INS;
        step();
        ins = 24'd0;
        step();
        step();
        chk("t6_done", 32'(in_service), 32'd0);

        // 6c: int_en=0 blocks grant but keeps pending
        int_en = 1'b0;
        irq_in = 4'b0000;
        step();
        irq_in = 4'b0100;
        step();
        step();
        step();
        step();
        chk_all("t6_disabled", 1'b0, 3'd1, 1'b0, 4'b0100);
        int_en = 1'b1;
        step();
        chk_all("t6_enabled", 1'b1, 3'd2, 1'b1, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
